// File: rtl/seq_multiplier_4bit_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier:
// FSM state codes and the number of partial-product iterations.
package seq_multiplier_4bit_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    // One iteration per multiplier bit.
    localparam int MUL_ITER = 4;

endpackage

// File: rtl/seq_multiplier_4bit_adder.sv
// 4-bit ripple adder with carry in/out; combines one partial product
// with the running accumulator.
module seq_multiplier_4bit_adder (
    output logic [3:0] sum,
    output logic       carry_out,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in
);

    // Zero-extend to five bits so the carry is the natural MSB of the sum.
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};

endmodule

// File: rtl/seq_multiplier_4bit.sv
// Multi-cycle unsigned 4x4 -> 8-bit shift-and-add multiplier.
// One partial-product add per clock, start/ready/busy/done handshake.
//
// state    | meaning
// ---------+--------------------------------------------------------
// MUL_IDLE | waiting for start; ready=1
// MUL_CALC | iterating, one add+shift per edge; busy=1
// MUL_DONE | product valid, one-cycle done pulse; ready=1
// (code 3) | unused, decodes to nothing and returns to MUL_IDLE
module seq_multiplier_4bit
    import seq_multiplier_4bit_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // The datapath is bound to the fixed 4-bit adder; no other width is legal.
    if (WIDTH != 4) begin : g_width_check
        $error("seq_multiplier_4bit: WIDTH must be 4");
    end

    mul_state_t state;
    mul_state_t state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [CNT_W-1:0]   count;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;
    logic [2*WIDTH-1:0] shifted;
    logic               last_iter;
    logic               accept;

    // Partial product is the multiplicand gated by the current multiplier LSB.
    assign addend = mq[0] ? mcand : '0;

    seq_multiplier_4bit_adder u_adder (
        .sum       (sum),
        .carry_out (carry),
        .a         (acc),
        .b         (addend),
        .carry_in  (1'b0)
    );

    // {carry, sum, mq} shifted right by one; the carry becomes the new acc MSB.
    assign shifted   = {carry, sum, mq[WIDTH-1:1]};
    assign last_iter = (count == CNT_W'(MUL_ITER - 1));
    assign accept    = ready & start;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the state register.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            MUL_IDLE: begin
                ready = 1'b1;
                if (start) state_next = MUL_CALC;
            end
            MUL_CALC: begin
                busy = 1'b1;
                if (last_iter) state_next = MUL_DONE;
            end
            MUL_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                state_next = start ? MUL_CALC : MUL_IDLE;
            end
            default: begin
                state_next = MUL_IDLE;
            end
        endcase
    end

    // Operand capture, add-and-shift iterations and the result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            count <= '0;
        end else if (state == MUL_CALC) begin
            acc   <= shifted[2*WIDTH-1:WIDTH];
            mq    <= shifted[WIDTH-1:0];
            count <= count + CNT_W'(1);
            if (last_iter) begin
                product <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier_4bit.sv
// Directed self-checking bench for seq_multiplier_4bit.
module tb_seq_multiplier_4bit;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    int dones;

    seq_multiplier_4bit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // 20-unit clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after an accept edge; counts busy cycles until done (bounded).
    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 12) begin
            busy_cycles++;
            tick();
        end
    endtask

    // Issue a one-cycle start and check latency, done pulse and product.
    task automatic run_op(input string tag, input logic [3:0] op_a, input logic [3:0] op_b,
                          input logic [7:0] exp);
        int bc;
        a = op_a; b = op_b; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(bc);
        check({tag, "_busy_cycles"}, 8'(bc), 8'd4);
        check({tag, "_done"}, {7'd0, done}, 8'd1);
        check({tag, "_product"}, product, exp);
        tick();
        check({tag, "_done_drop"}, {7'd0, done}, 8'd0);
        check({tag, "_hold"}, product, exp);
    endtask

    initial begin
        $monitor("t=%0t state=%0d acc=%h mq=%h product=%h", $time, dut.state, dut.acc, dut.mq,
                 dut.product);
        reset = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0;
        #25;
        check("rst_ready", {7'd0, ready}, 8'd1);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_product", product, 8'h00);
        reset = 1'b0;
        tick();

        // 1: 3*5
        run_op("t1", 4'd3, 4'd5, 8'h0F);

        // 2: 15*15 with carry visible in acc mid-run
        a = 4'd15; b = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_busy", {7'd0, busy}, 8'd1);
        tick();
        check("t2_acc_e1", {4'd0, dut.acc}, 8'h07);
        tick();
        check("t2_acc_e2_carry", {4'd0, dut.acc}, 8'h0B);
        tick(); tick();
        check("t2_done", {7'd0, done}, 8'd1);
        check("t2_product", product, 8'hE1);
        tick();

        // 3: zero operands
        run_op("t3a", 4'd0, 4'd9, 8'h00);
        run_op("t3b", 4'd9, 4'd0, 8'h00);

        // 4: start during CALC is ignored
        a = 4'd7; b = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; a = 4'd1; b = 4'd1;
        tick();
        start = 1'b0;
        check("t4_busy", {7'd0, busy}, 8'd1);
        tick(); tick();
        check("t4_done", {7'd0, done}, 8'd1);
        check("t4_product", product, 8'h2A);
        tick();
        check("t4_idle_ready", {7'd0, ready}, 8'd1);
        check("t4_no_restart", {7'd0, busy}, 8'd0);

        // 5: reset mid-operation
        a = 4'd6; b = 4'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        check("t5_rst_ready", {7'd0, ready}, 8'd1);
        check("t5_rst_busy", {7'd0, busy}, 8'd0);
        check("t5_rst_product", product, 8'h00);
        #5;
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check("t5_no_done", 8'(dones), 8'd0);
        run_op("t5", 4'd2, 4'd4, 8'h08);

        // 6: back-to-back with start held
        a = 4'd4; b = 4'd3; start = 1'b1;
        tick();
        wait_done(cyc);
        check("t6a_busy_cycles", 8'(cyc), 8'd4);
        check("t6a_done", {7'd0, done}, 8'd1);
        check("t6a_product", product, 8'h0C);
        a = 4'd5; b = 4'd5;
        tick();
        start = 1'b0;
        check("t6b_no_idle_gap", {7'd0, busy}, 8'd1);
        check("t6b_done_low", {7'd0, done}, 8'd0);
        wait_done(cyc);
        check("t6b_busy_cycles", 8'(cyc), 8'd4);
        check("t6b_done", {7'd0, done}, 8'd1);
        check("t6b_product", product, 8'h19);
        tick();
        check("t6b_done_drop", {7'd0, done}, 8'd0);

        $monitoroff;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
